// File: rtl/step_clock.sv
// Step sequencer clock: divides Clock into ticks and ticks into steps,
// walking StepIndex around a loop of STEPS columns while Play is high.
module step_clock #(
    parameter int PRESCALE = 50000,
    parameter int STEPS    = 16
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Play,
    input  logic [15:0] Period,
    output logic        Step,
    output logic [3:0]  StepIndex,
    output logic        LoopEnd,
    output logic        Running
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] presc;
    logic [15:0] ticks;
    logic [15:0] period_q;
    logic [3:0]  step_index;
    logic        step_q;
    logic        loop_end_q;
    logic        running_q;

    logic [15:0] period_in;
    logic        tick;
    logic        step_ev;
    logic        wrap;

    assign period_in = (Period == 16'd0) ? 16'd1 : Period;
    assign tick      = (presc == 16'(PRESCALE - 1));
    assign step_ev   = tick && (ticks == period_q - 16'd1);
    assign wrap      = (step_index == 4'(STEPS - 1));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            presc      <= '0;
            ticks      <= '0;
            period_q   <= 16'd1;
            step_index <= '0;
            step_q     <= 1'b0;
            loop_end_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    presc      <= '0;
                    ticks      <= '0;
                    step_index <= '0;
                    step_q     <= 1'b0;
                    loop_end_q <= 1'b0;
                    if (Play) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                        period_q  <= period_in;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!Play) begin
                        // a step due on this edge is dropped, not emitted
                        state      <= IDLE;
                        presc      <= '0;
                        ticks      <= '0;
                        step_index <= '0;
                        step_q     <= 1'b0;
                        loop_end_q <= 1'b0;
                        running_q  <= 1'b0;
                    end else begin
                        running_q  <= 1'b1;
                        step_q     <= step_ev;
                        loop_end_q <= step_ev && wrap;
                        presc      <= tick ? 16'd0 : presc + 16'd1;
                        if (tick) begin
                            ticks <= step_ev ? 16'd0 : ticks + 16'd1;
                        end
                        if (step_ev) begin
                            step_index <= wrap ? 4'd0 : step_index + 4'd1;
                            period_q   <= period_in;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Step      = step_q;
    assign StepIndex = step_index;
    assign LoopEnd   = loop_end_q;
    assign Running   = running_q;

endmodule

// File: tb/tb_step_clock.sv
// Directed bench for step_clock with PRESCALE=4, STEPS=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_step_clock;

    logic        Clock;
    logic        nReset;
    logic        Play;
    logic [15:0] Period;
    logic        Step;
    logic [3:0]  StepIndex;
    logic        LoopEnd;
    logic        Running;

    int n_checks;
    int n_fails;
    int cyc;

    step_clock #(
        .PRESCALE(4),
        .STEPS(16)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .Play(Play),
        .Period(Period),
        .Step(Step),
        .StepIndex(StepIndex),
        .LoopEnd(LoopEnd),
        .Running(Running)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // counts falling edges until Step is seen high; -1 on timeout
    task automatic wait_step(output int c);
        c = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            c++;
            if (Step) return;
        end
        check("step_timeout", 0, 1);
        c = -1;
    endtask

    // raise Play and return on the falling edge after the RUN entry edge
    task automatic start(input logic [15:0] p);
        Period = p;
        Play   = 1'b1;
        @(negedge Clock);
    endtask

    task automatic stop();
        Play = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        nReset   = 1'b0;
        Play     = 1'b0;
        Period   = 16'd3;

        repeat (2) @(negedge Clock);
        check("rst_step", int'(Step), 0);
        check("rst_idx", int'(StepIndex), 0);
        check("rst_loopend", int'(LoopEnd), 0);
        check("rst_running", int'(Running), 0);
        nReset = 1'b1;
        @(negedge Clock);
        check("idle_running", int'(Running), 0);

        // Period=3: step every 12 cycles, full loop of 16
        start(16'd3);
        check("run_entry", int'(Running), 1);
        check("run_idx0", int'(StepIndex), 0);
        check("run_step0", int'(Step), 0);
        for (int s = 1; s <= 16; s++) begin
            wait_step(cyc);
            check($sformatf("p3_interval_%0d", s), cyc, 12);
            check($sformatf("p3_idx_%0d", s), int'(StepIndex), s % 16);
            check($sformatf("p3_loopend_%0d", s), int'(LoopEnd), (s == 16) ? 1 : 0);
        end
        @(negedge Clock);
        check("step_width", int'(Step), 0);
        check("loopend_width", int'(LoopEnd), 0);
        stop();
        check("stop_running", int'(Running), 0);
        check("stop_idx", int'(StepIndex), 0);

        // Period=0 acts as Period=1
        start(16'd0);
        wait_step(cyc);
        check("p0_interval_1", cyc, 4);
        wait_step(cyc);
        check("p0_interval_2", cyc, 4);
        check("p0_idx", int'(StepIndex), 2);
        stop();

        // Period change mid-step only affects the following step
        start(16'd3);
        wait_step(cyc);
        check("chg_interval_1", cyc, 12);
        repeat (6) @(negedge Clock);
        Period = 16'd5;
        wait_step(cyc);
        check("chg_interval_2_rest", cyc, 6);
        wait_step(cyc);
        check("chg_interval_3", cyc, 20);
        check("chg_idx", int'(StepIndex), 3);
        stop();

        // Play dropped on the edge of a due step
        start(16'd3);
        wait_step(cyc);
        check("drop_first", cyc, 12);
        repeat (11) @(negedge Clock);
        Play = 1'b0;
        @(negedge Clock);
        check("drop_step", int'(Step), 0);
        check("drop_loopend", int'(LoopEnd), 0);
        check("drop_idx", int'(StepIndex), 0);
        check("drop_running", int'(Running), 0);
        @(negedge Clock);
        check("drop_step_after", int'(Step), 0);

        // asynchronous reset between clock edges during RUN
        start(16'd3);
        wait_step(cyc);
        check("ar_first", cyc, 12);
        repeat (3) @(negedge Clock);
        #2;
        nReset = 1'b0;
        Play   = 1'b0;
        #1;
        check("ar_running", int'(Running), 0);
        check("ar_idx", int'(StepIndex), 0);
        check("ar_step", int'(Step), 0);
        check("ar_loopend", int'(LoopEnd), 0);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        check("ar_idle", int'(Running), 0);
        start(16'd3);
        check("ar_restart_run", int'(Running), 1);
        check("ar_restart_idx", int'(StepIndex), 0);
        wait_step(cyc);
        check("ar_restart_interval", cyc, 12);
        check("ar_restart_idx1", int'(StepIndex), 1);
        stop();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/step_clock.md
STEP_CLOCK -- requirements
Module: step_clock

Interface
REQ-001 Parameter PRESCALE, default 50000, Clock cycles per tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter STEPS, default 16, steps per loop; StepIndex wraps at STEPS-1.
REQ-003 Port Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port nReset  input  1  reset, asynchronous, active-low.
REQ-005 Port Play  input  1  run enable from the loop counter; high = sequence runs, low = stop.
REQ-006 Port Period  input  16  step length in ticks; value 0 treated as 1.
REQ-007 Port Step  output  1  registered one-Clock-cycle pulse marking each step advance; drives the loop counter's step input.
REQ-008 Port StepIndex  output  4  current step column, 0..STEPS-1.
REQ-009 Port LoopEnd  output  1  one-cycle pulse coincident with the Step that wraps StepIndex to 0.
REQ-010 Port Running  output  1  high while in RUN.

Function
REQ-011 The block SHALL implement two states: IDLE and RUN.
REQ-012 In IDLE: prescaler, tick counter and StepIndex SHALL be held at 0; Step, LoopEnd and Running SHALL be 0.
REQ-013 IDLE -> RUN SHALL occur on the first Clock edge sampling Play=1; on that edge Period is latched (0 -> 1) and counters restart at 0.
REQ-014 In RUN, the prescaler SHALL count 0..PRESCALE-1 and wrap, generating a tick on the cycle it equals PRESCALE-1.
REQ-015 The tick counter SHALL advance on each tick; on the tick where it equals latched Period-1, it SHALL clear to 0 and a step event SHALL occur.
REQ-016 Step spacing SHALL be exactly PRESCALE*Period_latched Clock cycles; first Step asserts PRESCALE*Period_latched cycles after the RUN entry edge.
REQ-017 On a step event, Step SHALL be high for exactly one cycle and StepIndex SHALL increment; StepIndex=STEPS-1 SHALL wrap to 0.
REQ-018 LoopEnd SHALL pulse high on the same cycle as Step only when that step wraps StepIndex to 0.
REQ-019 Period SHALL be re-latched only at a step event; changes mid-step affect the following step.
REQ-020 RUN -> IDLE SHALL occur on the first edge sampling Play=0; all counters and outputs take IDLE values on that edge.
REQ-021 If Play=0 is sampled on the same edge a step event would occur, no Step or LoopEnd pulse SHALL be produced.
REQ-022 Step and LoopEnd SHALL come directly from flip-flops (glitch-free, usable as an edge source).
REQ-023 Counter widths: prescaler 16 bits, tick counter 16 bits; no overflow for legal parameters.

Reset
REQ-024 nReset=0 SHALL force IDLE immediately, independent of Clock, with Step=0, LoopEnd=0, Running=0, StepIndex=0, counters 0.
REQ-025 Reset asserted mid-RUN SHALL abort without a final Step pulse; after release, RUN re-enters only per REQ-013.
REQ-026 After nReset deasserts, the first Clock edge SHALL evaluate Play normally.

Verification (PRESCALE=4, STEPS=16 in bench)
REQ-027 Period=3, Play raised at cycle 0 -> Running=1 next edge; Step pulses every 12 cycles; StepIndex 1,2,3... after successive pulses.
REQ-028 Run 16 steps at Period=3 -> 16th Step coincides with LoopEnd=1 and StepIndex=0; no LoopEnd on steps 1-15.
REQ-029 Period=0 -> behaves as Period=1: Step every 4 cycles.
REQ-030 Change Period 3->5 midway through step 2 -> step 2 interval still 12 cycles, step 3 interval 20 cycles.
REQ-031 Drop Play on the exact edge of a due step -> no Step pulse, StepIndex=0, Running=0 next cycle.
REQ-032 Assert nReset between Clock edges during RUN -> all outputs 0 immediately; raising Play after release restarts with StepIndex=0 and first Step 12 cycles later.
